// File: rtl/serial_cmd_pkg.sv
// rtl/serial_cmd_pkg.sv - opcode constants, per-opcode tables and FSM state type for the serial command protocol
package serial_cmd_pkg;

  localparam logic [7:0] OP_VERSION     = 8'd0;
  localparam logic [7:0] OP_DEADTICKS   = 8'd1;
  localparam logic [7:0] OP_FIRINGTICKS = 8'd2;
  localparam logic [7:0] OP_TOGGLE_EN   = 8'd3;
  localparam logic [7:0] OP_CLKSWITCH   = 8'd4;
  localparam logic [7:0] OP_PHASE_ALL   = 8'd5;
  localparam logic [7:0] OP_PHASEOFF    = 8'd6;
  localparam logic [7:0] OP_FULLWIDTH   = 8'd7;
  localparam logic [7:0] OP_PASSTHRU    = 8'd8;
  localparam logic [7:0] OP_PHASEDIR    = 8'd9;
  localparam logic [7:0] OP_HISTO       = 8'd10;
  localparam logic [7:0] OP_VETOLAST    = 8'd11;
  localparam logic [7:0] OP_PHASE_C1    = 8'd12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_OP,
    ST_TX_GAP,
    ST_TX_ARG,
    ST_TX_DRAIN,
    ST_RECV,
    ST_DONE
  } state_e;

  function automatic logic op_nargs(input logic [7:0] op);
    return (op == OP_DEADTICKS) || (op == OP_FIRINGTICKS);
  endfunction

  // Unknown opcodes expect no reply so the master never waits on them.
  function automatic logic [4:0] op_rsp_len(input logic [7:0] op);
    case (op)
      OP_VERSION: return 5'd1;
      OP_HISTO:   return 5'd16;
      default:    return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/serial_rsp_collector.sv
// rtl/serial_rsp_collector.sv - little-endian response shift-in with saturating inter-byte timeout
module serial_rsp_collector #(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int TIMER_W        = 32
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clear_i,
  input  logic         start_i,
  input  logic         active_i,
  input  logic         rx_ready_i,
  input  logic [7:0]   rx_data_i,
  input  logic [4:0]   exp_len_i,
  output logic [127:0] data_o,
  output logic [4:0]   count_o,
  output logic         complete_o,
  output logic         expire_o
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [127:0]       data_q;
  logic [4:0]         count_q;
  logic [TIMER_W-1:0] timer_q;
  logic               store;

  assign store      = active_i && rx_ready_i;
  assign complete_o = store && ((count_q + 5'd1) == exp_len_i);
  // A byte landing on the expiry cycle wins over the timeout.
  assign expire_o   = active_i && !rx_ready_i && (timer_q == TIMER_LAST);
  assign data_o     = data_q;
  assign count_o    = count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q  <= '0;
      count_q <= '0;
      timer_q <= '0;
    end else begin
      if (clear_i) begin
        data_q  <= '0;
        count_q <= '0;
      end else if (store) begin
        data_q[{count_q[3:0], 3'b000} +: 8] <= rx_data_i;
        count_q <= count_q + 5'd1;
      end
      if (start_i || store) begin
        timer_q <= '0;
      end else if (active_i && (timer_q != '1)) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_cmd_initiator.sv
// rtl/serial_cmd_initiator.sv - sends opcode/argument bytes over UART and collects the fixed-length reply
module serial_cmd_initiator
  import serial_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int TIMER_W        = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [7:0]   cmd_opcode,
  input  logic [7:0]   cmd_arg,
  input  logic         txBusy,
  output logic         txStart,
  output logic [7:0]   txData,
  input  logic         rxReady,
  input  logic [7:0]   rxData,
  output logic         rsp_valid,
  output logic [127:0] rsp_data,
  output logic [4:0]   rsp_count,
  output logic         rsp_timeout,
  output logic         rx_stray
);

  state_e     state_q;
  logic [7:0] op_q;
  logic [7:0] arg_q;
  logic       arg_pending_q;
  logic       cmd_ready_q;
  logic       tx_start_q;
  logic [7:0] tx_data_q;
  logic       rsp_valid_q;
  logic       rsp_timeout_q;
  logic       rx_stray_q;

  logic       accept;
  logic [4:0] exp_len;
  logic       coll_start;
  logic       coll_complete;
  logic       coll_expire;

  assign accept     = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
  assign exp_len    = op_rsp_len(op_q);
  assign coll_start = (state_q == ST_TX_DRAIN) && !txBusy && (exp_len != 5'd0);

  serial_rsp_collector #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMER_W        (TIMER_W)
  ) u_collector (
    .clk_i      (clk),
    .reset_i    (reset),
    .clear_i    (accept),
    .start_i    (coll_start),
    .active_i   (state_q == ST_RECV),
    .rx_ready_i (rxReady),
    .rx_data_i  (rxData),
    .exp_len_i  (exp_len),
    .data_o     (rsp_data),
    .count_o    (rsp_count),
    .complete_o (coll_complete),
    .expire_o   (coll_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      arg_q         <= '0;
      arg_pending_q <= 1'b0;
      cmd_ready_q   <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rx_stray_q    <= 1'b0;
    end else begin
      tx_start_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rx_stray_q  <= rxReady && (state_q != ST_RECV);
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            op_q          <= cmd_opcode;
            arg_q         <= cmd_arg;
            arg_pending_q <= op_nargs(cmd_opcode);
            rsp_timeout_q <= 1'b0;
            cmd_ready_q   <= 1'b0;
            state_q       <= ST_TX_OP;
          end
        end
        ST_TX_OP: begin
          if (!txBusy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= op_q;
            state_q    <= ST_TX_GAP;
          end
        end
        // The strobe is visible here, giving the transmitter a cycle to raise busy.
        ST_TX_GAP: begin
          state_q <= arg_pending_q ? ST_TX_ARG : ST_TX_DRAIN;
        end
        ST_TX_ARG: begin
          if (!txBusy) begin
            tx_start_q    <= 1'b1;
            tx_data_q     <= arg_q;
            arg_pending_q <= 1'b0;
            state_q       <= ST_TX_GAP;
          end
        end
        ST_TX_DRAIN: begin
          if (!txBusy) begin
            if (exp_len == 5'd0) begin
              rsp_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_RECV;
            end
          end
        end
        ST_RECV: begin
          if (coll_complete) begin
            rsp_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if (coll_expire) begin
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= ST_DONE;
          end
        end
        ST_DONE: begin
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign txStart     = tx_start_q;
  assign txData      = tx_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rx_stray    = rx_stray_q;

endmodule
